// File: rtl/pe_gram_pkg.sv
// pe_gram_pkg
// Shared types and helpers for the Gram-matrix MAC processing element.
//   state_t        : PE sequencing state (IDLE, ACC)
//   cnt_width()    : width of the beat counter / k_len for a given LEN_MAX
//   sat_umax()     : unsigned saturation limit for an accumulator width
//   sat_smax()     : signed positive saturation limit
//   sat_smin()     : signed negative saturation limit
// The limit functions return LIMIT_W bits; callers slice to their ACC_W.
package pe_gram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int LIMIT_W = 128;

    function automatic int cnt_width(input int len_max);
        return $clog2(len_max + 1);
    endfunction

    // 2^acc_w - 1
    function automatic logic [LIMIT_W-1:0] sat_umax(input int acc_w);
        logic [LIMIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i < acc_w) v[i] = 1'b1;
        end
        return v;
    endfunction

    // 2^(acc_w-1) - 1
    function automatic logic [LIMIT_W-1:0] sat_smax(input int acc_w);
        logic [LIMIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i < acc_w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // -2^(acc_w-1) in acc_w-bit two's complement (only the sign bit set)
    function automatic logic [LIMIT_W-1:0] sat_smin(input int acc_w);
        logic [LIMIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_W; i++) begin
            if (i == acc_w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pe_gram_mult.sv
// pe_gram_mult
// Combinational DATA_W x DATA_W multiplier producing the full 2*DATA_W
// product, extended to ACC_W (sign-extended in signed mode, zero-extended
// otherwise).
// Ports:
//   a, b        in  DATA_W  operands
//   signed_mode in  1       1 = two's-complement operands
//   prod        out ACC_W   extended product
module pe_gram_mult #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    output logic [ACC_W-1:0]  prod
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] p;

    // The true product always fits in 2*DATA_W bits in either signedness,
    // so the low 2*DATA_W bits of the extended-operand product are exact.
    always_comb begin
        if (signed_mode) begin
            a_ext = {{DATA_W{a[DATA_W-1]}}, a};
            b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            a_ext = {{DATA_W{1'b0}}, a};
            b_ext = {{DATA_W{1'b0}}, b};
        end
        p = a_ext * b_ext;
    end

    generate
        if (ACC_W > PW) begin : g_ext
            assign prod = {{(ACC_W - PW){signed_mode & p[PW-1]}}, p};
        end else begin : g_noext
            assign prod = p;
        end
    endgenerate

endmodule

// File: rtl/pe_gram_mac.sv
// pe_gram_mac
// Systolic multiply-accumulate PE for the Gram-matrix array. Accumulates the
// dot product of an A/B operand stream over k_len beats (gaps allowed) and
// forwards both operands east/south with one cycle of delay.
// Optional build macro: PE_GRAM_SATURATE_EN -- clamp each accumulate on
// overflow instead of wrapping (ovf is flagged either way).
// Handshake: a beat is transferred on every rising edge with in_valid = 1;
// there is no backpressure. out_valid is in_valid delayed one cycle and
// res_valid is a single-cycle pulse in the cycle res takes a new value.
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   in_valid, in_a, in_b operand beat
//   k_len, signed_mode   vector length / arithmetic mode, sampled on beat 1
//   out_valid, out_a, out_b  forwarded operands (to east/south)
//   res, res_valid, res_ovf  completed dot product, pulse, overflow flag
//   busy                 high while a vector is partially accumulated
module pe_gram_mac
    import pe_gram_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  ACC_W   = 24,
    parameter int  LEN_MAX = 16,
    localparam int CNT_W   = cnt_width(LEN_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [CNT_W-1:0]  k_len,
    input  logic              signed_mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid,
    output logic              res_ovf,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LEN_MAX_C = CNT_W'(LEN_MAX);
`ifdef PE_GRAM_SATURATE_EN
    localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));
    localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
    localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
`endif

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   len, len_n;
    logic               mode, mode_n;
    logic               ovf, ovf_n;

    logic               emit;
    logic [ACC_W-1:0]   emit_val;
    logic               emit_ovf;

    logic               mult_signed;
    logic [ACC_W-1:0]   prod;
    logic [ACC_W:0]     sum_full;
    logic [ACC_W-1:0]   sum_wrap;
    logic [ACC_W-1:0]   sum_res;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   len_in;

    // The first beat uses the live signed_mode; later beats the latched one.
    assign mult_signed = (state == IDLE) ? signed_mode : mode;

    pe_gram_mult #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .a           (in_a),
        .b           (in_b),
        .signed_mode (mult_signed),
        .prod        (prod)
    );

    always_comb begin
        sum_full = {1'b0, acc} + {1'b0, prod};
        sum_wrap = sum_full[ACC_W-1:0];
        // Signed overflow: equal-sign operands producing an opposite-sign sum.
        if (mode) add_ovf = (acc[ACC_W-1] == prod[ACC_W-1]) &&
                            (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
        else      add_ovf = sum_full[ACC_W];
`ifdef PE_GRAM_SATURATE_EN
        if (add_ovf) begin
            if (mode) sum_res = acc[ACC_W-1] ? SMIN : SMAX;
            else      sum_res = UMAX;
        end else begin
            sum_res = sum_wrap;
        end
`else
        sum_res = sum_wrap;
`endif
        cnt_inc = cnt + CNT_W'(1);
        len_in  = ((k_len == '0) || (k_len > LEN_MAX_C)) ? LEN_MAX_C : k_len;
    end

    // Next-state and datapath control.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        len_n    = len;
        mode_n   = mode;
        ovf_n    = ovf;
        emit     = 1'b0;
        emit_val = acc;
        emit_ovf = ovf;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    len_n  = len_in;
                    mode_n = signed_mode;
                    acc_n  = prod;
                    cnt_n  = CNT_W'(1);
                    ovf_n  = 1'b0;
                    if (len_in == CNT_W'(1)) begin
                        emit     = 1'b1;
                        emit_val = prod;
                        emit_ovf = 1'b0;
                    end else begin
                        state_n = ACC;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_n = sum_res;
                    cnt_n = cnt_inc;
                    ovf_n = ovf | add_ovf;
                    if (cnt_inc == len) begin
                        emit     = 1'b1;
                        emit_val = sum_res;
                        emit_ovf = ovf | add_ovf;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            len       <= LEN_MAX_C;
            mode      <= 1'b0;
            ovf       <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            acc       <= acc_n;
            cnt       <= cnt_n;
            len       <= len_n;
            mode      <= mode_n;
            ovf       <= ovf_n;
            res_valid <= emit;
            if (emit) begin
                res     <= emit_val;
                res_ovf <= emit_ovf;
            end
            out_valid <= in_valid;
            if (in_valid) begin
                out_a <= in_a;
                out_b <= in_b;
            end
        end
    end

    assign busy = (state == ACC);

endmodule

// File: tb/tb_pe_gram_mac.sv
// tb_pe_gram_mac
// Directed bench for pe_gram_mac. Two instances share the stimulus: the
// default build (ACC_W = 24) and a narrow one (ACC_W = 16) for overflow.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_pe_gram_mac;

    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [CNT_W-1:0] k_len;
    logic             signed_mode;

    logic             out_valid;
    logic [7:0]       out_a;
    logic [7:0]       out_b;
    logic [23:0]      res;
    logic             res_valid;
    logic             res_ovf;
    logic             busy;

    logic             out_valid16;
    logic [7:0]       out_a16;
    logic [7:0]       out_b16;
    logic [15:0]      res16;
    logic             res_valid16;
    logic             res_ovf16;
    logic             busy16;

    int checks   = 0;
    int failures = 0;

    pe_gram_mac #(.DATA_W(8), .ACC_W(24), .LEN_MAX(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .k_len(k_len), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .res(res), .res_valid(res_valid), .res_ovf(res_ovf), .busy(busy)
    );

    pe_gram_mac #(.DATA_W(8), .ACC_W(16), .LEN_MAX(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .k_len(k_len), .signed_mode(signed_mode),
        .out_valid(out_valid16), .out_a(out_a16), .out_b(out_b16),
        .res(res16), .res_valid(res_valid16), .res_ovf(res_ovf16), .busy(busy16)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_a"},     32'(out_a),       32'd0);
        check({tag, "_out_b"},     32'(out_b),       32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_res"},       32'(res),         32'd0);
        check({tag, "_res_valid"}, 32'(res_valid),   32'd0);
        check({tag, "_res_ovf"},   32'(res_ovf),     32'd0);
        check({tag, "_busy"},      32'(busy),        32'd0);
        check({tag, "_res16"},     32'(res16),       32'd0);
        check({tag, "_busy16"},    32'(busy16),      32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        k_len       = '0;
        signed_mode = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;

        // Unsigned sum of squares: 1+4+9+16 = 30
        k_len = 5'd4;
        signed_mode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            beat(8'(i), 8'(i));
            check("sq_out_a",     32'(out_a),     32'(i));
            check("sq_out_valid", 32'(out_valid), 32'd1);
            check("sq_res_valid", 32'(res_valid), (i == 4) ? 32'd1 : 32'd0);
            check("sq_busy",      32'(busy),      (i < 4) ? 32'd1 : 32'd0);
        end
        check("sq_res",     32'(res),     32'd30);
        check("sq_res_ovf", 32'(res_ovf), 32'd0);
        idle();
        check("sq_pulse_end", 32'(res_valid), 32'd0);
        check("sq_res_hold",  32'(res),       32'd30);
        check("sq_out_valid_low", 32'(out_valid), 32'd0);
        check("sq_out_a_hold", 32'(out_a),    32'd4);

        // Signed: (-1*3) + (-2*4) = -11; mode/length changes mid-vector ignored
        signed_mode = 1'b1;
        k_len = 5'd2;
        beat(8'hFF, 8'd3);
        check("sgn_busy",      32'(busy),      32'd1);
        check("sgn_res_valid", 32'(res_valid), 32'd0);
        signed_mode = 1'b0;
        k_len = 5'd7;
        beat(8'hFE, 8'd4);
        check("sgn_res_valid2", 32'(res_valid), 32'd1);
        check("sgn_res",        32'(res),       32'h00FFFFF5);
        check("sgn_res16",      32'(res16),     32'h0000FFF5);
        check("sgn_ovf",        32'(res_ovf),   32'd0);
        check("sgn_ovf16",      32'(res_ovf16), 32'd0);
        idle();

        // Gaps of 2 idle cycles between beats
        signed_mode = 1'b0;
        k_len = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            beat(8'(i), 8'(i));
            check("gap_res_valid", 32'(res_valid), (i == 4) ? 32'd1 : 32'd0);
            check("gap_out_valid", 32'(out_valid), 32'd1);
            if (i < 4) begin
                k_len = 5'd1;
                for (int g = 0; g < 2; g++) begin
                    idle();
                    check("gap_out_valid_low", 32'(out_valid), 32'd0);
                    check("gap_out_a_hold",    32'(out_a),     32'(i));
                    check("gap_out_b_hold",    32'(out_b),     32'(i));
                    check("gap_no_pulse",      32'(res_valid), 32'd0);
                    check("gap_busy",          32'(busy),      32'd1);
                end
            end
        end
        check("gap_res", 32'(res), 32'd30);
        idle();

        // Back-to-back vectors: 2*2+3*3 = 13, then 1*5+1*5 = 10
        k_len = 5'd2;
        beat(8'd2, 8'd2);
        beat(8'd3, 8'd3);
        check("b2b_valid1", 32'(res_valid), 32'd1);
        check("b2b_res1",   32'(res),       32'd13);
        beat(8'd1, 8'd5);
        check("b2b_gap_valid", 32'(res_valid), 32'd0);
        check("b2b_busy",      32'(busy),      32'd1);
        check("b2b_res_hold",  32'(res),       32'd13);
        beat(8'd1, 8'd5);
        check("b2b_valid2", 32'(res_valid), 32'd1);
        check("b2b_res2",   32'(res),       32'd10);
        check("b2b_out_b",  32'(out_b),     32'd5);
        idle();

        // Unsigned overflow at 16 bits: 65025 * 2 = 130050
        k_len = 5'd2;
        signed_mode = 1'b0;
        beat(8'd255, 8'd255);
        beat(8'd255, 8'd255);
        check("uovf_valid16", 32'(res_valid16), 32'd1);
`ifdef PE_GRAM_SATURATE_EN
        check("uovf_res16",   32'(res16),       32'd65535);
`else
        check("uovf_res16",   32'(res16),       32'd64514);
`endif
        check("uovf_flag16",  32'(res_ovf16),   32'd1);
        check("uovf_res24",   32'(res),         32'd130050);
        check("uovf_flag24",  32'(res_ovf),     32'd0);
        // Next vector starts with a clean flag
        k_len = 5'd1;
        beat(8'd1, 8'd1);
        check("uovf_next_res16",  32'(res16),       32'd1);
        check("uovf_next_flag16", 32'(res_ovf16),   32'd0);
        check("uovf_next_valid",  32'(res_valid16), 32'd1);
        check("len1_busy",        32'(busy),        32'd0);

        // Signed overflow at 16 bits: 6400 * 2 = 12800 fits; use 128*... via
        // (-128)*(-128) = 16384 twice = 32768 (exceeds +32767)
        k_len = 5'd2;
        signed_mode = 1'b1;
        beat(8'h80, 8'h80);
        beat(8'h80, 8'h80);
`ifdef PE_GRAM_SATURATE_EN
        check("sovf_res16",  32'(res16),     32'h7FFF);
`else
        check("sovf_res16",  32'(res16),     32'h8000);
`endif
        check("sovf_flag16", 32'(res_ovf16), 32'd1);
        check("sovf_res24",  32'(res),       32'h008000);
        check("sovf_flag24", 32'(res_ovf),   32'd0);
        idle();

        // k_len = 0 clamps to LEN_MAX = 16
        k_len = 5'd0;
        signed_mode = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            beat(8'd1, 8'd1);
            check("clamp_res_valid", 32'(res_valid), (i == 16) ? 32'd1 : 32'd0);
        end
        check("clamp_res", 32'(res), 32'd16);
        idle();

        // Reset mid-vector discards the partial sum
        k_len = 5'd4;
        beat(8'd9, 8'd9);
        beat(8'd9, 8'd9);
        check("rmid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check_all_zero("rmid");
        rst = 1'b1;
        idle();
        check("rmid_no_pulse", 32'(res_valid), 32'd0);
        check("rmid_idle",     32'(busy),      32'd0);
        k_len = 5'd1;
        beat(8'd7, 8'd6);
        check("rmid_res",       32'(res),       32'd42);
        check("rmid_res_valid", 32'(res_valid), 32'd1);
        check("rmid_busy",      32'(busy),      32'd0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
